// File: rtl/sweep_checker.sv
// Exhaustive stimulus sweep that compares N implementation channels against golden channel 0
// under a per-bit care mask, accumulating a saturating mismatch count, fail map and first failure.
module sweep_checker #(
  parameter int unsigned A_WIDTH       = 4,
  parameter int unsigned Y_WIDTH       = 8,
  parameter int unsigned NCH           = 2,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 16,
  localparam int unsigned CH_W         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NCH*Y_WIDTH-1:0] y_in,
  input  logic [Y_WIDTH-1:0]     y_care,
  output logic [A_WIDTH-1:0]     a_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       mismatch_count,
  output logic [NCH-1:0]         mismatch_map,
  output logic [A_WIDTH-1:0]     first_a,
  output logic [CH_W-1:0]        first_ch,
  output logic [Y_WIDTH-1:0]     first_diff
);

  localparam int unsigned NF_W  = $clog2(NCH) + 1;
  localparam int unsigned SUM_W = CNT_W + NF_W;
  localparam int unsigned SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SettleLast = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [SUM_W-1:0] CntMax     = {{NF_W{1'b0}}, {CNT_W{1'b1}}};

  typedef enum logic [1:0] {StIdle, StSettle, StCheck, StDone} state_e;

  state_e              state;
  logic [SC_W-1:0]     settle_cnt;
  logic                first_seen;

  logic [Y_WIDTH-1:0]  golden;
  logic [Y_WIDTH-1:0]  diff_c;
  logic [NCH-1:0]      fail;
  logic [NF_W-1:0]     nfail;
  logic                found;
  logic [CH_W-1:0]     low_ch;
  logic [Y_WIDTH-1:0]  low_diff;
  logic [SUM_W-1:0]    sum;
  logic [CNT_W-1:0]    count_next;

  // Channel 0 is never compared, so fail[0] and mismatch_map[0] stay 0.
  always_comb begin
    golden   = y_in[Y_WIDTH-1:0];
    diff_c   = '0;
    fail     = '0;
    nfail    = '0;
    found    = 1'b0;
    low_ch   = '0;
    low_diff = '0;
    for (int c = 1; c < NCH; c++) begin
      diff_c  = (y_in[c*Y_WIDTH +: Y_WIDTH] ^ golden) & y_care;
      fail[c] = |diff_c;
      nfail   = nfail + NF_W'(fail[c]);
      if (fail[c] && !found) begin
        found    = 1'b1;
        low_ch   = CH_W'(c);
        low_diff = diff_c;
      end
    end
  end

  always_comb begin
    sum        = SUM_W'(mismatch_count) + SUM_W'(nfail);
    count_next = (sum > CntMax) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= StIdle;
      settle_cnt     <= '0;
      first_seen     <= 1'b0;
      a_out          <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mismatch_count <= '0;
      mismatch_map   <= '0;
      first_a        <= '0;
      first_ch       <= '0;
      first_diff     <= '0;
    end else begin
      case (state)
        StIdle, StDone: begin
          if (start) begin
            state          <= StSettle;
            settle_cnt     <= '0;
            first_seen     <= 1'b0;
            a_out          <= '0;
            busy           <= 1'b1;
            done           <= 1'b0;
            pass           <= 1'b0;
            mismatch_count <= '0;
            mismatch_map   <= '0;
            first_a        <= '0;
            first_ch       <= '0;
            first_diff     <= '0;
          end
        end
        StSettle: begin
          if (abort) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else if (settle_cnt == SettleLast) begin
            state <= StCheck;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        StCheck: begin
          // Abort wins over the update, so this vector's result is dropped.
          if (abort) begin
            state <= StIdle;
            busy  <= 1'b0;
          end else begin
            mismatch_count <= count_next;
            mismatch_map   <= mismatch_map | fail;
            if (found && !first_seen) begin
              first_seen <= 1'b1;
              first_a    <= a_out;
              first_ch   <= low_ch;
              first_diff <= low_diff;
            end
            if (&a_out) begin
              state <= StDone;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (count_next == '0);
            end else begin
              a_out      <= a_out + 1'b1;
              settle_cnt <= '0;
              state      <= StSettle;
            end
          end
        end
        default: begin
          state <= StIdle;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sweep_checker.sv
// Directed bench for sweep_checker: table of sweep scenarios plus abort, saturation,
// three-channel and asynchronous-reset sequences.
module tb_sweep_checker;

  logic clk = 1'b0;
  logic rst, start, abort;
  always #5 clk = ~clk;

  // Main instance: defaults (A=4, Y=8, NCH=2, SETTLE=2, CNT_W=16)
  logic [15:0] y_in;
  logic [7:0]  y_care;
  logic [3:0]  a_out, first_a;
  logic        busy, done, pass;
  logic [15:0] mismatch_count;
  logic [1:0]  mismatch_map;
  logic [0:0]  first_ch;
  logic [7:0]  first_diff;

  // Three-channel instance
  logic [23:0] y3_in;
  logic [3:0]  a3, first_a3;
  logic        busy3, done3, pass3;
  logic [15:0] count3;
  logic [2:0]  map3;
  logic [1:0]  first_ch3;
  logic [7:0]  first_diff3;

  // Narrow-counter instance
  logic [15:0] yc_in;
  logic [3:0]  ac, first_ac;
  logic        busyc, donec, passc;
  logic [2:0]  countc;
  logic [1:0]  mapc;
  logic [0:0]  first_chc;
  logic [7:0]  first_diffc;

  sweep_checker dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y_in), .y_care(y_care),
    .a_out(a_out), .busy(busy), .done(done), .pass(pass), .mismatch_count(mismatch_count),
    .mismatch_map(mismatch_map), .first_a(first_a), .first_ch(first_ch),
    .first_diff(first_diff)
  );

  sweep_checker #(.NCH(3)) dut3 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(y3_in), .y_care(8'hFF),
    .a_out(a3), .busy(busy3), .done(done3), .pass(pass3), .mismatch_count(count3),
    .mismatch_map(map3), .first_a(first_a3), .first_ch(first_ch3), .first_diff(first_diff3)
  );

  sweep_checker #(.CNT_W(3)) dutc (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y_in(yc_in), .y_care(8'hFF),
    .a_out(ac), .busy(busyc), .done(donec), .pass(passc), .mismatch_count(countc),
    .mismatch_map(mapc), .first_a(first_ac), .first_ch(first_chc), .first_diff(first_diffc)
  );

  int mode;
  int errors = 0;
  int checks = 0;
  logic [7:0] flip;

  function automatic logic [7:0] gold(input logic [3:0] a);
    return {a, ~a};
  endfunction

  always_comb begin
    flip = 8'h00;
    case (mode)
      1: flip = (a_out == 4'd5) ? 8'h01 : 8'h00;
      2: flip = 8'h80;
      3: flip = (a_out == 4'd15) ? 8'h3C : 8'h00;
      4: flip = 8'hA5;
      default: flip = 8'h00;
    endcase
    y_in = {gold(a_out) ^ flip, gold(a_out)};
  end

  always_comb y3_in = {gold(a3) ^ (((a3 == 4'd3) || (a3 == 4'd9)) ? 8'h10 : 8'h00),
                       gold(a3) ^ ((a3 == 4'd3) ? 8'h01 : 8'h00), gold(a3)};
  always_comb yc_in = {gold(ac) ^ 8'h55, gold(ac)};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_sweep(output int cyc);
    pulse_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    check("a_after_start", {28'd0, a_out}, 32'd0);
    check("count_after_start", {16'd0, mismatch_count}, 32'd0);
    cyc = 0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) break;
    end
  endtask

  typedef struct {
    int         mode;
    logic [7:0] care;
    int         cnt;
    logic       pass;
    logic [3:0] fa;
    logic       fch;
    logic [7:0] fd;
    logic [1:0] map;
  } vec_t;

  vec_t tbl[6];
  int   cyc;
  int   abort_at[2];

  initial begin
    tbl[0] = '{0, 8'hFF, 0,  1'b1, 4'd0,  1'b0, 8'h00, 2'b00};
    tbl[1] = '{1, 8'hFF, 1,  1'b0, 4'd5,  1'b1, 8'h01, 2'b10};
    tbl[2] = '{2, 8'h7F, 0,  1'b1, 4'd0,  1'b0, 8'h00, 2'b00};
    tbl[3] = '{3, 8'hFF, 1,  1'b0, 4'd15, 1'b1, 8'h3C, 2'b10};
    tbl[4] = '{4, 8'h0F, 16, 1'b0, 4'd0,  1'b1, 8'h05, 2'b10};
    tbl[5] = '{4, 8'h00, 0,  1'b1, 4'd0,  1'b0, 8'h00, 2'b00};
    abort_at[0] = 10;
    abort_at[1] = 12;

    rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0; y_care = 8'hFF;
    #12;
    check("rst_a_out", {28'd0, a_out}, 32'd0);
    check("rst_flags", {29'd0, busy, done, pass}, 32'd0);
    check("rst_count", {16'd0, mismatch_count}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Three-channel and saturation instances run alongside the main one
    run_sweep(cyc);
    check("multi_latency", cyc, 48);
    check("ch3_done", {31'd0, done3}, 32'd1);
    check("ch3_count", {16'd0, count3}, 32'd3);
    check("ch3_first_a", {28'd0, first_a3}, 32'd3);
    check("ch3_first_ch", {30'd0, first_ch3}, 32'd1);
    check("ch3_first_diff", {24'd0, first_diff3}, 32'h01);
    check("ch3_map", {29'd0, map3}, 32'b110);
    check("ch3_pass", {31'd0, pass3}, 32'd0);
    check("sat_count", {29'd0, countc}, 32'd7);
    check("sat_first_a", {28'd0, first_ac}, 32'd0);
    check("sat_first_diff", {24'd0, first_diffc}, 32'h55);
    check("sat_map", {30'd0, mapc}, 32'b10);
    check("sat_pass", {31'd0, passc}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      mode   = tbl[i].mode;
      y_care = tbl[i].care;
      run_sweep(cyc);
      check($sformatf("v%0d_latency", i), cyc, 48);
      check($sformatf("v%0d_done", i), {31'd0, done}, 32'd1);
      check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
      check($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, tbl[i].pass});
      check($sformatf("v%0d_count", i), {16'd0, mismatch_count}, tbl[i].cnt);
      check($sformatf("v%0d_map", i), {30'd0, mismatch_map}, {30'd0, tbl[i].map});
      check($sformatf("v%0d_first_a", i), {28'd0, first_a}, {28'd0, tbl[i].fa});
      check($sformatf("v%0d_first_ch", i), {31'd0, first_ch}, {31'd0, tbl[i].fch});
      check($sformatf("v%0d_first_diff", i), {24'd0, first_diff}, {24'd0, tbl[i].fd});
    end

    // Abort in SETTLE (cycle 10) and in CHECK (cycle 12): vectors 0..2 counted only
    mode   = 4;
    y_care = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      pulse_start();
      repeat (abort_at[i] - 1) @(posedge clk);
      #1;
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check($sformatf("abort%0d_busy", i), {31'd0, busy}, 32'd0);
      check($sformatf("abort%0d_done", i), {31'd0, done}, 32'd0);
      check($sformatf("abort%0d_count", i), {16'd0, mismatch_count}, 32'd3);
      check($sformatf("abort%0d_map", i), {30'd0, mismatch_map}, 32'b10);
      repeat (3) @(posedge clk);
      #1;
      check($sformatf("abort%0d_idle_busy", i), {31'd0, busy}, 32'd0);
    end

    mode = 0;
    run_sweep(cyc);
    check("restart_latency", cyc, 48);
    check("restart_pass", {31'd0, pass}, 32'd1);
    check("restart_map", {30'd0, mismatch_map}, 32'd0);

    // Asynchronous reset while CHECK is the current state
    mode = 4;
    pulse_start();
    repeat (5) @(posedge clk);
    #3;
    check("prereset_busy", {31'd0, busy}, 32'd1);
    check("prereset_count", {16'd0, mismatch_count}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_a_out", {28'd0, a_out}, 32'd0);
    check("async_flags", {29'd0, busy, done, pass}, 32'd0);
    check("async_count", {16'd0, mismatch_count}, 32'd0);
    check("async_map", {30'd0, mismatch_map}, 32'd0);
    check("async_first", {19'd0, first_a, first_ch, first_diff}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sweep_checker.md
# sweep_checker

Sequential exhaustive-sweep checker for the expression-equivalence flow. It drives every value of an `A_WIDTH`-bit stimulus bus into externally connected combinational implementations of one expression. After a settle window it compares each implementation's output against channel 0, the golden channel, under a per-bit care mask, so that undef golden bits are excluded. It accumulates a mismatch count, a per-channel fail map and the first failing vector. It is the clocked, multi-channel successor of the fixed single-expression test modules, for use in hardware-in-the-loop and simulation regressions.

## Interface
- `A_WIDTH`, 4: stimulus width; the sweep covers 0 .. 2^A_WIDTH-1.
- `Y_WIDTH`, 8: width of each implementation output.
- `NCH`, 2: number of channels (≥2); channel 0 is golden.
- `SETTLE_CYCLES`, 2: cycles `a_out` is held stable before comparison (≥1).
- `CNT_W`, 16: mismatch counter width.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin sweep; sampled in IDLE or DONE only.
- `abort`  in  1  stop sweep; sampled in SETTLE or CHECK only.
- `y_in`  in  NCH*Y_WIDTH  channel c at bits [c*Y_WIDTH +: Y_WIDTH].
- `y_care`  in  Y_WIDTH  1 = bit is compared; sampled in CHECK.
- `a_out`  out  A_WIDTH  registered stimulus.
- `busy`  out  1  high in SETTLE/CHECK.
- `done`  out  1  high in DONE.
- `pass`  out  1  done and mismatch_count==0.
- `mismatch_count`  out  CNT_W  failing (vector, channel) pairs, saturating.
- `mismatch_map`  out  NCH  sticky per-channel fail bits; bit 0 constant 0.
- `first_a`  out  A_WIDTH  stimulus of first failing vector.
- `first_ch`  out  clog2(NCH)  lowest failing channel index at that vector.
- `first_diff`  out  Y_WIDTH  masked XOR of that channel vs golden.

## Operation
- States: IDLE, SETTLE, CHECK, DONE. All outputs are registered.
- Reset (async, any state): enter IDLE. Every output resets to 0, including a_out, counters, map and first_* fields.
- IDLE/DONE with `start`=1:
  - Go to SETTLE.
  - Clear a_out, mismatch_count, mismatch_map, first_* and the internal first-seen flag.
  - Settle counter = 0.
- SETTLE: the settle counter increments each cycle. On the edge where it equals SETTLE_CYCLES-1, go to CHECK.
- CHECK (one cycle):
  - For c = 1..NCH-1: diff_c = (y_c ^ y_0) & y_care. Channel c fails if diff_c != 0.
  - mismatch_count += number of failing channels; saturate at 2^CNT_W-1 (no wrap).
  - mismatch_map[c] |= fail_c.
  - If any channel fails and first-seen is 0: capture first_a=a_out, first_ch=lowest failing c, first_diff=diff_c; set first-seen.
  - If a_out is all ones: go to DONE; a_out holds.
  - Otherwise: a_out+1, clear the settle counter, go to SETTLE.
- DONE: holds all results with done=1 until `start` or reset.
- `abort` in SETTLE/CHECK:
  - Go to IDLE. Results so far are retained; done stays 0.
  - abort has priority over the CHECK update; that vector's result is discarded.
- `start` while busy is ignored. `abort` in IDLE/DONE is ignored. start and abort together in IDLE/DONE: start wins.
- The golden channel never counts as a mismatch, even when y_care=0.

## Timing
- Edge k samples start=1. From edge k: busy=1 and a_out=0.
- Each vector occupies SETTLE_CYCLES+1 cycles. y_in must be valid by the CHECK cycle, i.e. within SETTLE_CYCLES clocks of an a_out change.
- done rises on edge k + 2^A_WIDTH·(SETTLE_CYCLES+1). busy falls on the same edge.
- Count, map and first_* update on the CHECK edge and are visible the following cycle.
- Abort sampled at edge j: busy=0 from edge j.

## Test plan
- A_WIDTH=4, NCH=2, SETTLE=2; y_1=y_0 for all vectors, y_care=8'hFF:
  - done rises exactly 48 cycles after start, pass=1, count=0, map=2'b00.
- y_1 = y_0 ^ 8'h01 only when a_out==5:
  - count=1, first_a=5, first_ch=1, first_diff=8'h01, map=2'b10, pass=0.
- y_1 = y_0 ^ 8'h80 for all vectors, y_care=8'h7F:
  - pass=1, count=0.
- NCH=3: ch1 and ch2 fail at a=3, ch2 also fails at a=9:
  - count=3, first_a=3, first_ch=1, map=3'b110.
- CNT_W=3; ch1 fails on every vector:
  - count saturates at 7 (no wrap); first_a=0.
- abort asserted on cycle 10 after start:
  - busy=0 next cycle, done=0.
  - A new start clears the results and the sweep restarts with a_out=0.
- rst asserted asynchronously mid-CHECK:
  - All outputs are 0 immediately, without waiting for a clock edge.
